// File: rtl/count_checker_if.sv
// Bus between an observed up-counter and its checker: sampled count, qualifier,
// error-clear request and the checker's status outputs.
interface count_checker_if #(
   parameter int WIDTH    = 4,
   parameter int ERRCNT_W = 8
) ();
   logic [0:WIDTH-1]    count_in;
   logic                valid_in;
   logic                clr_err;
   logic                locked;
   logic                err_pulse;
   logic [ERRCNT_W-1:0] err_count;
   logic [0:WIDTH-1]    expected;

   modport master (
      output count_in, valid_in, clr_err,
      input  locked, err_pulse, err_count, expected
   );

   modport slave (
      input  count_in, valid_in, clr_err,
      output locked, err_pulse, err_count, expected
   );
endinterface

// File: rtl/count_checker.sv
// Sequence checker for a free-running up-counter: locks onto +1 steps and
// flags breaks. Define COUNT_CHECKER_STICKY_EN to make a break latch FAULT.
module count_checker #(
   parameter int WIDTH    = 4,
   parameter int LOCK_CNT = 2,
   parameter int ERRCNT_W = 8
) (
   input logic           clk,
   input logic           rst,
   count_checker_if.slave bus
);

`ifdef COUNT_CHECKER_STICKY_EN
   typedef enum logic [1:0] {IDLE, ACQUIRE, LOCKED, FAULT} state_t;
`else
   typedef enum logic [1:0] {IDLE, ACQUIRE, LOCKED} state_t;
`endif

   state_t              state_q;
   logic [3:0]          run_q;
   logic [0:WIDTH-1]    expected_q;
   logic                locked_q;
   logic                err_pulse_q;
   logic [ERRCNT_W-1:0] err_count_q;

   logic                match;
   logic                err_det;
   logic                lock_hit;
   logic [4:0]          run_inc;
   logic [0:WIDTH-1]    samp_inc;
   logic [0:WIDTH-1]    exp_inc;

   function automatic logic [ERRCNT_W-1:0] sat_inc(input logic [ERRCNT_W-1:0] v);
      return (&v) ? v : v + ERRCNT_W'(1);
   endfunction

   assign match    = (bus.count_in == expected_q);
   assign samp_inc = bus.count_in + WIDTH'(1);
   assign exp_inc  = expected_q + WIDTH'(1);
   assign run_inc  = {1'b0, run_q} + 5'd1;
   assign lock_hit = (run_inc == 5'(LOCK_CNT));
   assign err_det  = bus.valid_in && (state_q == LOCKED) && !match;

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         state_q     <= IDLE;
         run_q       <= '0;
         expected_q  <= '0;
         locked_q    <= 1'b0;
         err_pulse_q <= 1'b0;
         err_count_q <= '0;
      end else begin
         err_pulse_q <= 1'b0;
         // A clear coinciding with a new error leaves that error counted.
         if (bus.clr_err)
            err_count_q <= err_det ? ERRCNT_W'(1) : '0;
         else if (err_det)
            err_count_q <= sat_inc(err_count_q);

         if (bus.valid_in) begin
            case (state_q)
               IDLE: begin
                  expected_q <= samp_inc;
                  run_q      <= '0;
                  state_q    <= ACQUIRE;
               end
               ACQUIRE: begin
                  if (match) begin
                     expected_q <= exp_inc;
                     run_q      <= run_inc[3:0];
                     if (lock_hit) begin
                        state_q  <= LOCKED;
                        locked_q <= 1'b1;
                     end
                  end else begin
                     expected_q <= samp_inc;
                     run_q      <= '0;
                  end
               end
               LOCKED: begin
                  if (match) begin
                     expected_q <= exp_inc;
                  end else begin
                     err_pulse_q <= 1'b1;
                     locked_q    <= 1'b0;
`ifdef COUNT_CHECKER_STICKY_EN
                     // expected stays at the value that was violated
                     state_q     <= FAULT;
`else
                     expected_q  <= samp_inc;
                     run_q       <= '0;
                     state_q     <= ACQUIRE;
`endif
                  end
               end
`ifdef COUNT_CHECKER_STICKY_EN
               FAULT: begin
                  state_q <= FAULT;
               end
`endif
               default: begin
                  state_q  <= IDLE;
                  locked_q <= 1'b0;
               end
            endcase
         end
      end
   end

   assign bus.locked    = locked_q;
   assign bus.err_pulse = err_pulse_q;
   assign bus.err_count = err_count_q;
   assign bus.expected  = expected_q;

endmodule
